// File: rtl/lemming_pkg.sv
// Shared types and helpers for the lemming walker controller.
// Optional revive support is enabled with the LEMMING_REVIVE_EN macro.
package lemming_pkg;

    localparam int LEM_NUM_DFLT        = 4;
    localparam int LEM_FALL_LIMIT_DFLT = 20;
    localparam int LEM_DIG_LIMIT_DFLT  = 0;

    typedef enum logic [2:0] {
        WALK_L = 3'd0,
        WALK_R = 3'd1,
        FALL_L = 3'd2,
        FALL_R = 3'd3,
        DIG_L  = 3'd4,
        DIG_R  = 3'd5,
        SPLAT  = 3'd6
    } lem_state_t;

    // Counter width able to hold 0..limit, never narrower than one bit.
    function automatic int cnt_width(input int limit);
        return (limit < 1) ? 1 : $clog2(limit + 1);
    endfunction

    // Walking state that keeps the direction of a falling/digging state.
    function automatic lem_state_t to_walk(input lem_state_t st);
        case (st)
            WALK_R, FALL_R, DIG_R: return WALK_R;
            default:               return WALK_L;
        endcase
    endfunction

    function automatic lem_state_t to_fall(input lem_state_t st);
        case (st)
            WALK_R, FALL_R, DIG_R: return FALL_R;
            default:               return FALL_L;
        endcase
    endfunction

endpackage

// File: rtl/lemming_core.sv
// Single lemming channel: walk/fall/dig/splat FSM with saturating fall
// counter and optional dig timeout. Revive port exists under LEMMING_REVIVE_EN.
module lemming_core
    import lemming_pkg::*;
#(
    parameter int FALL_LIMIT = LEM_FALL_LIMIT_DFLT,
    parameter int DIG_LIMIT  = LEM_DIG_LIMIT_DFLT
) (
    input  logic clk,
    input  logic areset,
    input  logic bump_left,
    input  logic bump_right,
    input  logic ground,
    input  logic dig,
`ifdef LEMMING_REVIVE_EN
    input  logic revive,
`endif
    output logic walk_left,
    output logic walk_right,
    output logic aaah,
    output logic digging,
    output logic dead
);

    localparam int FW = cnt_width(FALL_LIMIT);
    localparam int DW = cnt_width((DIG_LIMIT > 0) ? DIG_LIMIT - 1 : 0);
    localparam logic [FW-1:0] FALL_MAX = FW'(FALL_LIMIT);
    localparam logic [DW-1:0] DIG_LAST = DW'((DIG_LIMIT > 0) ? DIG_LIMIT - 1 : 0);

    lem_state_t    state_r, state_nxt_s;
    logic [FW-1:0] fall_cnt_r, fall_nxt_s;
    logic [DW-1:0] dig_cnt_r, dig_nxt_s;

    // State and counter registers.
    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_r    <= WALK_L;
            fall_cnt_r <= '0;
            dig_cnt_r  <= '0;
        end else begin
            state_r    <= state_nxt_s;
            fall_cnt_r <= fall_nxt_s;
            dig_cnt_r  <= dig_nxt_s;
        end
    end

    // Next-state and counter update.
    always_comb begin
        state_nxt_s = state_r;
        fall_nxt_s  = fall_cnt_r;
        dig_nxt_s   = dig_cnt_r;
        case (state_r)
            WALK_L, WALK_R: begin
                if (!ground) begin
                    state_nxt_s = to_fall(state_r);
                    fall_nxt_s  = '0;
                end else if (dig) begin
                    state_nxt_s = (state_r == WALK_L) ? DIG_L : DIG_R;
                    dig_nxt_s   = '0;
                end else if ((state_r == WALK_L) ? bump_left : bump_right) begin
                    state_nxt_s = (state_r == WALK_L) ? WALK_R : WALK_L;
                end else begin
                    state_nxt_s = state_r;
                end
            end
            FALL_L, FALL_R: begin
                if (!ground) begin
                    fall_nxt_s = (fall_cnt_r < FALL_MAX) ? fall_cnt_r + 1'b1 : fall_cnt_r;
                end else if (fall_cnt_r >= FALL_MAX) begin
                    state_nxt_s = SPLAT;
                end else begin
                    state_nxt_s = to_walk(state_r);
                end
            end
            DIG_L, DIG_R: begin
                // Losing the ground wins over a timeout in the same cycle.
                if (!ground) begin
                    state_nxt_s = to_fall(state_r);
                    fall_nxt_s  = '0;
                end else if ((DIG_LIMIT > 0) && (dig_cnt_r == DIG_LAST)) begin
                    state_nxt_s = to_walk(state_r);
                end else begin
                    dig_nxt_s = (DIG_LIMIT > 0) ? dig_cnt_r + 1'b1 : '0;
                end
            end
            SPLAT: begin
`ifdef LEMMING_REVIVE_EN
                if (revive) begin
                    state_nxt_s = WALK_L;
                    fall_nxt_s  = '0;
                    dig_nxt_s   = '0;
                end else begin
                    state_nxt_s = SPLAT;
                end
`else
                state_nxt_s = SPLAT;
`endif
            end
            default: begin
                state_nxt_s = WALK_L;
                fall_nxt_s  = '0;
                dig_nxt_s   = '0;
            end
        endcase
    end

    assign walk_left  = (state_r == WALK_L);
    assign walk_right = (state_r == WALK_R);
    assign aaah       = (state_r == FALL_L) || (state_r == FALL_R);
    assign digging    = (state_r == DIG_L) || (state_r == DIG_R);
    assign dead       = (state_r == SPLAT);

endmodule

// File: rtl/lemming_array_ctrl.sv
// Array of independent lemming channels with dead-count aggregation.
// Optional per-channel revive input is enabled with LEMMING_REVIVE_EN.
module lemming_array_ctrl
    import lemming_pkg::*;
#(
    parameter int NUM_LEM    = LEM_NUM_DFLT,
    parameter int FALL_LIMIT = LEM_FALL_LIMIT_DFLT,
    parameter int DIG_LIMIT  = LEM_DIG_LIMIT_DFLT
) (
    input  logic                            clk,
    input  logic                            areset,
    input  logic [NUM_LEM-1:0]              bump_left,
    input  logic [NUM_LEM-1:0]              bump_right,
    input  logic [NUM_LEM-1:0]              ground,
    input  logic [NUM_LEM-1:0]              dig,
`ifdef LEMMING_REVIVE_EN
    input  logic [NUM_LEM-1:0]              revive,
`endif
    output logic [NUM_LEM-1:0]              walk_left,
    output logic [NUM_LEM-1:0]              walk_right,
    output logic [NUM_LEM-1:0]              aaah,
    output logic [NUM_LEM-1:0]              digging,
    output logic [NUM_LEM-1:0]              dead,
    output logic [$clog2(NUM_LEM+1)-1:0]    dead_cnt,
    output logic                            all_dead
);

    localparam int CW = $clog2(NUM_LEM + 1);

    logic [CW-1:0] dead_cnt_s;

    for (genvar g = 0; g < NUM_LEM; g++) begin : g_lem
        lemming_core #(
            .FALL_LIMIT (FALL_LIMIT),
            .DIG_LIMIT  (DIG_LIMIT)
        ) u_core (
            .clk        (clk),
            .areset     (areset),
            .bump_left  (bump_left[g]),
            .bump_right (bump_right[g]),
            .ground     (ground[g]),
            .dig        (dig[g]),
`ifdef LEMMING_REVIVE_EN
            .revive     (revive[g]),
`endif
            .walk_left  (walk_left[g]),
            .walk_right (walk_right[g]),
            .aaah       (aaah[g]),
            .digging    (digging[g]),
            .dead       (dead[g])
        );
    end

    // Population count of splatted channels.
    always_comb begin
        dead_cnt_s = '0;
        for (int i = 0; i < NUM_LEM; i++) begin
            dead_cnt_s = dead_cnt_s + CW'(dead[i]);
        end
    end

    assign dead_cnt = dead_cnt_s;
    assign all_dead = (dead_cnt_s == CW'(NUM_LEM));

endmodule

// File: tb/tb_lemming_array_ctrl.sv
// Directed self-checking bench for lemming_array_ctrl (NUM_LEM=4,
// FALL_LIMIT=20, DIG_LIMIT=8); revive scenario runs when LEMMING_REVIVE_EN is set.
module tb_lemming_array_ctrl;

    logic       clk = 1'b0;
    logic       areset = 1'b1;
    logic [3:0] bump_left = 4'b0, bump_right = 4'b0, ground = 4'b1111, dig = 4'b0;
`ifdef LEMMING_REVIVE_EN
    logic [3:0] revive = 4'b0;
`endif
    logic [3:0] walk_left, walk_right, aaah, digging, dead;
    logic [2:0] dead_cnt;
    logic       all_dead;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lemming_array_ctrl #(.NUM_LEM(4), .FALL_LIMIT(20), .DIG_LIMIT(8)) dut (
        .clk        (clk),
        .areset     (areset),
        .bump_left  (bump_left),
        .bump_right (bump_right),
        .ground     (ground),
        .dig        (dig),
`ifdef LEMMING_REVIVE_EN
        .revive     (revive),
`endif
        .walk_left  (walk_left),
        .walk_right (walk_right),
        .aaah       (aaah),
        .digging    (digging),
        .dead       (dead),
        .dead_cnt   (dead_cnt),
        .all_dead   (all_dead)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        step(2);
        checks++; if (walk_left !== 4'b1111) begin errors++; $display("FAIL reset_walk_left got %b exp 1111", walk_left); end
        checks++; if ({walk_right, aaah, digging, dead} !== 16'h0) begin errors++; $display("FAIL reset_others got %h exp 0000", {walk_right, aaah, digging, dead}); end
        checks++; if (dead_cnt !== 3'd0 || all_dead !== 1'b0) begin errors++; $display("FAIL reset_cnt got %0d/%b exp 0/0", dead_cnt, all_dead); end
        areset = 1'b0;
        step(1);
        checks++; if (walk_left !== 4'b1111) begin errors++; $display("FAIL reset_release got %b exp 1111", walk_left); end
    endtask

    task automatic test_bump();
        bump_left = 4'b0001; step(1); bump_left = 4'b0;
        checks++; if (walk_right !== 4'b0001 || walk_left !== 4'b1110) begin errors++; $display("FAIL bump_turn got R%b L%b exp R0001 L1110", walk_right, walk_left); end
        checks++; if (dead_cnt !== 3'd0) begin errors++; $display("FAIL bump_dead_cnt got %0d exp 0", dead_cnt); end
        bump_right = 4'b0010; step(1); bump_right = 4'b0;
        checks++; if (walk_left !== 4'b1110) begin errors++; $display("FAIL bump_wrong_side got %b exp 1110", walk_left); end
        bump_left = 4'b0001; bump_right = 4'b0001; step(1);
        bump_left = 4'b0; bump_right = 4'b0;
        checks++; if (walk_left !== 4'b1111 || walk_right !== 4'b0000) begin errors++; $display("FAIL bump_both got L%b R%b exp L1111 R0000", walk_left, walk_right); end
    endtask

    task automatic test_fall_survive();
        ground = 4'b1101; dig = 4'b0010; bump_left = 4'b0010;
        for (int i = 0; i < 5; i++) begin
            step(1);
            checks++; if (aaah !== 4'b0010) begin errors++; $display("FAIL fall_short_aaah cyc %0d got %b exp 0010", i, aaah); end
        end
        ground = 4'b1111;
        step(1); dig = 4'b0; bump_left = 4'b0;
        checks++; if (walk_left !== 4'b1111 || aaah !== 4'b0000 || dead !== 4'b0000) begin errors++; $display("FAIL fall_short_land got L%b A%b D%b exp L1111 A0000 D0000", walk_left, aaah, dead); end
        // 20 falling edges leave the counter at 19: survives.
        ground = 4'b1101; step(20); ground = 4'b1111; step(1);
        checks++; if (walk_left[1] !== 1'b1 || dead[1] !== 1'b0) begin errors++; $display("FAIL fall_limit_minus1 got L%b D%b exp 1 0", walk_left[1], dead[1]); end
    endtask

    task automatic test_splat();
        ground = 4'b1011; step(25);
        checks++; if (aaah !== 4'b0100) begin errors++; $display("FAIL splat_falling got %b exp 0100", aaah); end
        ground = 4'b1111; step(1);
        checks++; if (dead !== 4'b0100 || dead_cnt !== 3'd1 || all_dead !== 1'b0) begin errors++; $display("FAIL splat_dead got %b cnt %0d all %b exp 0100 1 0", dead, dead_cnt, all_dead); end
        bump_left = 4'b0100; dig = 4'b0100; step(1);
        bump_left = 4'b0; dig = 4'b0; ground = 4'b1011; step(2); ground = 4'b1111;
        checks++; if (dead !== 4'b0100 || walk_left !== 4'b1011 || aaah !== 4'b0000 || digging !== 4'b0000) begin errors++; $display("FAIL splat_absorb got D%b L%b A%b G%b", dead, walk_left, aaah, digging); end
    endtask

    task automatic test_dig();
        bump_left = 4'b1000; step(1); bump_left = 4'b0;
        checks++; if (walk_right !== 4'b1000) begin errors++; $display("FAIL dig_face_right got %b exp 1000", walk_right); end
        dig = 4'b1000; step(1); dig = 4'b0;
        for (int i = 0; i < 8; i++) begin
            checks++; if (digging !== 4'b1000) begin errors++; $display("FAIL dig_active cyc %0d got %b exp 1000", i, digging); end
            step(1);
        end
        checks++; if (walk_right !== 4'b1000 || digging !== 4'b0000) begin errors++; $display("FAIL dig_timeout got R%b G%b exp R1000 G0000", walk_right, digging); end
        // Ground loss on the timeout cycle must win.
        dig = 4'b1000; step(1); dig = 4'b0; step(7);
        ground = 4'b0111; step(1);
        checks++; if (aaah !== 4'b1000 || digging !== 4'b0000) begin errors++; $display("FAIL dig_fall_prio got A%b G%b exp A1000 G0000", aaah, digging); end
        dig = 4'b1000; ground = 4'b1111; step(1);
        checks++; if (walk_right !== 4'b1000 || digging !== 4'b0000) begin errors++; $display("FAIL dig_land_dir got R%b G%b exp R1000 G0000", walk_right, digging); end
        step(1); dig = 4'b0;
        checks++; if (digging !== 4'b1000) begin errors++; $display("FAIL dig_after_land got %b exp 1000", digging); end
    endtask

    task automatic test_kill_all();
        ground = 4'b0000; step(21);
        checks++; if (aaah !== 4'b1011 || dead_cnt !== 3'd1) begin errors++; $display("FAIL kill_mid got A%b cnt %0d exp A1011 1", aaah, dead_cnt); end
        ground = 4'b1111; step(1);
        checks++; if (dead !== 4'b1111 || dead_cnt !== 3'd4 || all_dead !== 1'b1) begin errors++; $display("FAIL kill_all got %b cnt %0d all %b exp 1111 4 1", dead, dead_cnt, all_dead); end
        #2 areset = 1'b1; #1;
        checks++; if (walk_left !== 4'b1111 || all_dead !== 1'b0 || dead_cnt !== 3'd0) begin errors++; $display("FAIL kill_areset got L%b all %b cnt %0d exp 1111 0 0", walk_left, all_dead, dead_cnt); end
        step(1); areset = 1'b0; step(1);
        checks++; if (walk_left !== 4'b1111 || dead !== 4'b0000) begin errors++; $display("FAIL kill_post_reset got L%b D%b exp 1111 0000", walk_left, dead); end
    endtask

`ifdef LEMMING_REVIVE_EN
    task automatic test_revive();
        ground = 4'b1110; step(21); ground = 4'b1111; step(1);
        checks++; if (dead !== 4'b0001) begin errors++; $display("FAIL revive_setup got %b exp 0001", dead); end
        revive = 4'b0011; step(1); revive = 4'b0;
        checks++; if (walk_left !== 4'b1111 || dead !== 4'b0000 || dead_cnt !== 3'd0) begin errors++; $display("FAIL revive_walk got L%b D%b cnt %0d exp 1111 0000 0", walk_left, dead, dead_cnt); end
    endtask
`endif

    initial begin
        test_reset();
        test_bump();
        test_fall_survive();
        test_splat();
        test_dig();
        test_kill_all();
`ifdef LEMMING_REVIVE_EN
        test_revive();
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
